// File: rtl/oam_dma.sv
// OAM DMA engine: copies LENGTH bytes from page_q*0x100 into OAM, one byte per
// cycle, with a one-cycle read-to-write pipeline and abort-on-restart.
module oam_dma #(
  parameter int unsigned LENGTH       = 160,
  parameter int unsigned SETUP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [7:0]       LAST_IDX   = 8'(LENGTH - 1);
  localparam logic [CNT_W-1:0] LAST_SETUP = CNT_W'(SETUP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DRAIN} state_t;

  // Pages 0xE0-0xFF alias the work RAM at 0xC0-0xDF.
  function automatic logic [7:0] eff_page(input logic [7:0] p);
    return (p >= 8'hE0) ? p - 8'h20 : p;
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       page_q, page_d;
  logic [7:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_pend_q, wr_pend_d;
  logic [7:0]       wr_idx_q, wr_idx_d;
  logic             done_q, done_d;
  logic [15:0]      rd_addr_q, rd_addr_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wr_pend_d = 1'b0;
    wr_idx_d  = wr_idx_q;
    done_d    = 1'b0;

    // Address/data outputs hold their last driven value while idle.
    rd_en     = (state_q == XFER);
    rd_addr   = rd_en ? {page_q, idx_q} : rd_addr_q;
    wr_en     = wr_pend_q;
    wr_addr   = wr_pend_q ? wr_idx_q : wr_addr_q;
    wr_data   = wr_pend_q ? rd_data : wr_data_q;
    busy      = (state_q != IDLE);
    done      = done_q;
    rd_addr_d = rd_addr;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;

    unique case (state_q)
      IDLE: ;
      SETUP: begin
        if (cnt_q == LAST_SETUP) begin
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        wr_pend_d = 1'b1;
        wr_idx_d  = idx_q;
        if (idx_q == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A start in any state (re)launches a transfer; in-flight work is discarded.
    if (start) begin
      state_d   = SETUP;
      page_d    = eff_page(src_page);
      idx_d     = 8'd0;
      cnt_d     = '0;
      wr_pend_d = 1'b0;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      page_q    <= 8'h00;
      idx_q     <= 8'h00;
      cnt_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 8'h00;
      done_q    <= 1'b0;
      rd_addr_q <= 16'h0000;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      done_q    <= done_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: a default-length and a LENGTH=1 instance share random and
// directed stimulus; a cycle-level transfer model checks both every cycle.
module tb_oam_dma;

  localparam int S    = 1;
  localparam int LEN0 = 160;
  localparam int LEN1 = 1;

  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] src_page;

  logic        rd_en0, wr_en0, busy0, done0, rd_en1, wr_en1, busy1, done1;
  logic [15:0] rd_addr0, rd_addr1;
  logic [7:0]  rd_data0, rd_data1, wr_addr0, wr_addr1, wr_data0, wr_data1;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  oam_dma dut0 (
    .clk(clk), .rst(rst), .start(start), .src_page(src_page),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0)
  );

  oam_dma #(.LENGTH(LEN1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .src_page(src_page),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory contents: page 0xC0 holds i^0x5A at offset i.
  function automatic logic [7:0] memfn(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] ^ 8'hC0);
  endfunction

  // Memory answers one cycle after a read; otherwise returns junk.
  always @(posedge clk) begin
    rd_data0 <= rd_en0 ? memfn(rd_addr0) : 8'($urandom);
    rd_data1 <= rd_en1 ? memfn(rd_addr1) : 8'($urandom);
  end

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, got, want);
    end
  endtask

  // Transfer model: a transfer started in cycle t0 is fully described by rel=cyc-t0.
  bit          m_valid = 0;
  bit          m_act [2];
  int          m_t0 [2];
  logic [7:0]  m_page [2];
  logic [15:0] m_lra [2];
  logic [7:0]  m_lwa [2];
  logic [7:0]  m_lwd [2];

  task automatic model_step(input int k, input logic b, input logic re, input logic [15:0] ra,
                            input logic we, input logic [7:0] wa, input logic [7:0] wd,
                            input logic dn);
    int L, rel;
    logic eb, er, ew, ed;
    logic [15:0] era;
    logic [7:0] ewa, ewd;
    L   = (k == 0) ? LEN0 : LEN1;
    rel = m_act[k] ? (cyc - m_t0[k]) : -1;
    eb  = m_act[k] && rel >= 1 && rel <= S + L + 1;
    er  = m_act[k] && rel >= S + 1 && rel <= S + L;
    ew  = m_act[k] && rel >= S + 2 && rel <= S + L + 1;
    ed  = m_act[k] && rel == S + L + 2;
    era = er ? {m_page[k], 8'(rel - S - 1)} : m_lra[k];
    ewa = ew ? 8'(rel - S - 2) : m_lwa[k];
    ewd = ew ? memfn({m_page[k], ewa}) : m_lwd[k];
    chk("busy", k, 32'(b), 32'(eb));
    chk("rd_en", k, 32'(re), 32'(er));
    chk("rd_addr", k, 32'(ra), 32'(era));
    chk("wr_en", k, 32'(we), 32'(ew));
    chk("wr_addr", k, 32'(wa), 32'(ewa));
    chk("wr_data", k, 32'(wd), 32'(ewd));
    chk("done", k, 32'(dn), 32'(ed));
    m_lra[k] = era;
    m_lwa[k] = ewa;
    m_lwd[k] = ewd;
    if (rel >= S + L + 2) m_act[k] = 0;
  endtask

  task automatic model_inputs(input int k);
    if (rst) begin
      m_act[k] = 0;
      m_lra[k] = 16'h0;
      m_lwa[k] = 8'h0;
      m_lwd[k] = 8'h0;
    end else if (start) begin
      m_act[k]  = 1;
      m_t0[k]   = cyc;
      m_page[k] = (src_page >= 8'hE0) ? src_page - 8'h20 : src_page;
    end
  endtask

  // Event log for the directed literal checks.
  int log_frd [2], log_lwr [2], log_done [2], log_ndone [2], log_nwr [2], log_nbusy [2];
  logic [15:0] log_fra [2], log_lra [2];
  logic [7:0]  log_wd16;

  task automatic clear_log();
    for (int k = 0; k < 2; k++) begin
      log_frd[k] = -1; log_lwr[k] = -1; log_done[k] = -1;
      log_ndone[k] = 0; log_nwr[k] = 0; log_nbusy[k] = 0;
      log_fra[k] = 16'hxxxx; log_lra[k] = 16'hxxxx;
    end
    log_wd16 = 8'hxx;
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      model_step(0, busy0, rd_en0, rd_addr0, wr_en0, wr_addr0, wr_data0, done0);
      model_step(1, busy1, rd_en1, rd_addr1, wr_en1, wr_addr1, wr_data1, done1);
    end
    if (rst) m_valid = 1;
    model_inputs(0);
    model_inputs(1);
    if (rd_en0) begin
      if (log_frd[0] < 0) begin log_frd[0] = cyc; log_fra[0] = rd_addr0; end
      log_lra[0] = rd_addr0;
    end
    if (rd_en1) begin
      if (log_frd[1] < 0) begin log_frd[1] = cyc; log_fra[1] = rd_addr1; end
      log_lra[1] = rd_addr1;
    end
    if (wr_en0) begin
      log_lwr[0] = cyc; log_nwr[0]++;
      if (wr_addr0 == 8'd16) log_wd16 = wr_data0;
    end
    if (wr_en1) begin log_lwr[1] = cyc; log_nwr[1]++; end
    if (done0) begin log_done[0] = cyc; log_ndone[0]++; end
    if (done1) begin log_done[1] = cyc; log_ndone[1]++; end
    if (busy0) log_nbusy[0]++;
    if (busy1) log_nbusy[1]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] p);
    start = 1'b1;
    src_page = p;
    tick();
    start = 1'b0;
    src_page = 8'($urandom);
  endtask

  int mark;

  initial begin
    rst = 1'b1; start = 1'b0; src_page = 8'h00;
    clear_log();
    repeat (3) tick();
    chk("rst_busy", 0, 32'(busy0), 32'd0);
    chk("rst_rd_en", 0, 32'(rd_en0), 32'd0);
    chk("rst_wr_en", 0, 32'(wr_en0), 32'd0);
    chk("rst_rd_addr", 0, 32'(rd_addr0), 32'h0000);
    chk("rst_wr_addr", 0, 32'(wr_addr0), 32'h00);
    chk("rst_wr_data", 0, 32'(wr_data0), 32'h00);
    chk("rst_done", 0, 32'(done0), 32'd0);
    rst = 1'b0;

    // Basic copy from page 0xC0, started in the first cycle out of reset.
    clear_log(); mark = cyc;
    pulse(8'hC0);
    repeat (169) tick();
    chk("basic_first_rd", 0, 32'(log_frd[0] - mark), 32'd2);
    chk("basic_first_ra", 0, 32'(log_fra[0]), 32'hC000);
    chk("basic_last_wr", 0, 32'(log_lwr[0] - mark), 32'd162);
    chk("basic_done", 0, 32'(log_done[0] - mark), 32'd163);
    chk("basic_ndone", 0, 32'(log_ndone[0]), 32'd1);
    chk("basic_nwr", 0, 32'(log_nwr[0]), 32'd160);
    chk("basic_nbusy", 0, 32'(log_nbusy[0]), 32'd162);
    chk("basic_wd16", 0, 32'(log_wd16), 32'h4A);
    chk("len1_rd", 1, 32'(log_frd[1] - mark), 32'd2);
    chk("len1_wr", 1, 32'(log_lwr[1] - mark), 32'd3);
    chk("len1_done", 1, 32'(log_done[1] - mark), 32'd4);
    chk("len1_nbusy", 1, 32'(log_nbusy[1]), 32'd3);
    chk("len1_nwr", 1, 32'(log_nwr[1]), 32'd1);

    // Echo-RAM mirror pages.
    clear_log();
    pulse(8'hE1);
    repeat (169) tick();
    chk("mirror_e1_first", 0, 32'(log_fra[0]), 32'hC100);
    chk("mirror_e1_last", 0, 32'(log_lra[0]), 32'hC19F);
    clear_log();
    pulse(8'hFF);
    repeat (169) tick();
    chk("mirror_ff_first", 0, 32'(log_fra[0]), 32'hDF00);
    chk("mirror_ff_last", 0, 32'(log_lra[0]), 32'hDF9F);

    // Restart 50 cycles into a transfer.
    clear_log(); mark = cyc;
    pulse(8'hC0);
    repeat (49) tick();
    pulse(8'hD0);
    repeat (175) tick();
    chk("restart_ndone", 0, 32'(log_ndone[0]), 32'd1);
    chk("restart_done", 0, 32'(log_done[0] - mark), 32'd213);
    chk("restart_nwr", 0, 32'(log_nwr[0]), 32'd208);

    // Reset 80 cycles into a transfer, then a clean transfer.
    clear_log(); mark = cyc;
    pulse(8'hC0);
    repeat (79) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("rstmid_ndone", 0, 32'(log_ndone[0]), 32'd0);
    chk("rstmid_last_wr", 0, 32'(log_lwr[0] - mark), 32'd80);
    clear_log();
    pulse(8'hC3);
    repeat (169) tick();
    chk("after_rst_ndone", 0, 32'(log_ndone[0]), 32'd1);
    chk("after_rst_nwr", 0, 32'(log_nwr[0]), 32'd160);

    // Random start/reset traffic, model-checked every cycle.
    repeat (3000) begin
      start = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 299) == 0);
      src_page = 8'($urandom_range(0, 255));
      tick();
    end
    start = 1'b0; rst = 1'b0;
    repeat (200) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
